// File: rtl/result_wb_pkg.sv
// Shared types and geometry helpers for the result writeback stage.
// entry_t carries one buffered word together with its precomputed output address.
package result_wb_pkg;

    localparam int RWB_D_W_ACC = 16;
    localparam int RWB_N1      = 4;
    localparam int RWB_N2      = 4;
    localparam int RWB_M       = 8;

    function automatic int addr_width(input int m);
        return $clog2(m * m);
    endfunction

    function automatic int tile_count(input int m, input int n1, input int n2);
        return (m / n1) * (m / n2);
    endfunction

    localparam int RWB_ADDR_W = addr_width(RWB_M);

    typedef struct packed {
        logic [RWB_ADDR_W-1:0]  addr;
        logic [RWB_D_W_ACC-1:0] data;
    } entry_t;

endpackage

// File: rtl/row_fifo.sv
// Synchronous FIFO of address/data entries, one instance per array row.
// Latency: show-ahead head, push visible on the next cycle.
// Backpressure: a push into a full FIFO is accepted only with a same-cycle pop.
module row_fifo
    import result_wb_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  entry_t push_dat,
    input  logic   pop,
    output entry_t head,
    output logic   full,
    output logic   empty
);

    localparam int PW = $clog2(DEPTH);

    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/result_writeback.sv
// Collects per-row result streams, addresses each word and serialises them round-robin onto one write port.
// Latency: 1 cycle from valid_D to wr_en when the row FIFO is empty and the port is free.
// Backpressure: wr_ready low holds the output register; rows buffer in FIFOs, excess words are dropped and flag overflow.
// Build option RESULT_WB_RELU_EN clamps negative words to zero at capture.
module result_writeback
    import result_wb_pkg::*;
#(
    parameter int D_W_ACC    = RWB_D_W_ACC,
    parameter int N1         = RWB_N1,
    parameter int N2         = RWB_N2,
    parameter int M          = RWB_M,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [D_W_ACC-1:0]      D [N1-1:0],
    input  logic [N1-1:0]           valid_D,
    input  logic                    wr_ready,
    output logic                    wr_en,
    output logic [$clog2(M*M)-1:0]  wr_addr,
    output logic [D_W_ACC-1:0]      wr_data,
    output logic                    done,
    output logic                    overflow
);

    localparam int AW    = addr_width(M);
    localparam int TILES = tile_count(M, N1, N2);
    localparam int CS    = M / N2;
    localparam int KW    = (N2 > 1) ? $clog2(N2) : 1;
    localparam int TW    = (TILES > 1) ? $clog2(TILES) : 1;
    localparam int PW    = (N1 > 1) ? $clog2(N1) : 1;
    localparam int TOTAL = M * M;
    localparam int CW    = $clog2(TOTAL);

    logic [N1-1:0] row_avail;
    logic [N1-1:0] fifo_empty;
    logic [N1-1:0] fifo_full;
    logic [N1-1:0] ovf_vec;
    logic [N1-1:0] grant_vec;
    entry_t        row_head [N1];

    logic          out_load;
    logic          grant_any;
    logic [PW-1:0] grant_idx;
    logic [PW-1:0] rr_ptr;
    logic [CW-1:0] wr_cnt;
    entry_t        sel_entry;

    for (genvar i = 0; i < N1; i++) begin : g_row
        logic [KW-1:0]      k_cnt;
        logic [TW-1:0]      t_cnt;
        logic [AW-1:0]      row_addr;
        logic [D_W_ACC-1:0] row_data;
        entry_t             cap_entry;
        entry_t             fifo_head;
        logic               fifo_push;
        logic               fifo_pop;

        always_ff @(posedge clk) begin
            if (rst) begin
                k_cnt <= '0;
                t_cnt <= '0;
            end else if (valid_D[i]) begin
                if (k_cnt == KW'(N2-1)) begin
                    k_cnt <= '0;
                    t_cnt <= (t_cnt == TW'(TILES-1)) ? '0 : t_cnt + 1'b1;
                end else begin
                    k_cnt <= k_cnt + 1'b1;
                end
            end
        end

        // Farthest PE drains first, so the k-th word of a tile is column N2-1-k.
        assign row_addr = AW'(((int'(t_cnt) / CS) * N1 + i) * M
                              + (int'(t_cnt) % CS) * N2 + (N2 - 1 - int'(k_cnt)));

`ifdef RESULT_WB_RELU_EN
        assign row_data = D[i][D_W_ACC-1] ? '0 : D[i];
`else
        assign row_data = D[i];
`endif

        assign cap_entry = '{addr: row_addr, data: row_data};

        // An empty FIFO lets a granted incoming word bypass straight to the output register.
        assign row_avail[i] = !fifo_empty[i] || valid_D[i];
        assign row_head[i]  = fifo_empty[i] ? cap_entry : fifo_head;
        assign fifo_pop     = grant_vec[i] && !fifo_empty[i];
        assign fifo_push    = valid_D[i] && !(fifo_empty[i] && grant_vec[i]);
        assign ovf_vec[i]   = valid_D[i] && fifo_full[i] && !fifo_pop;

        row_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .push     (fifo_push),
            .push_dat (cap_entry),
            .pop      (fifo_pop),
            .head     (fifo_head),
            .full     (fifo_full[i]),
            .empty    (fifo_empty[i])
        );
    end

    always_comb begin
        out_load  = !wr_en || wr_ready;
        grant_any = 1'b0;
        grant_idx = '0;
        grant_vec = '0;
        if (out_load) begin
            for (int j = 0; j < N1; j++) begin
                if (!grant_any && row_avail[(int'(rr_ptr) + j) % N1]) begin
                    grant_any = 1'b1;
                    grant_idx = PW'((int'(rr_ptr) + j) % N1);
                end
            end
        end
        if (grant_any) grant_vec[grant_idx] = 1'b1;
    end

    assign sel_entry = row_head[grant_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            rr_ptr  <= '0;
        end else if (out_load) begin
            wr_en <= grant_any;
            if (grant_any) begin
                wr_addr <= sel_entry.addr;
                wr_data <= sel_entry.data;
                rr_ptr  <= (grant_idx == PW'(N1-1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt   <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            if (wr_en && wr_ready) begin
                if (wr_cnt == CW'(TOTAL-1)) begin
                    wr_cnt <= '0;
                    done   <= 1'b1;
                end else begin
                    wr_cnt <= wr_cnt + 1'b1;
                end
            end
            if (|ovf_vec) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_result_writeback.sv
// Self-checking bench for result_writeback: vector table, hand sequences and a per-row scoreboard.
module tb_result_writeback;

    localparam int N1 = 4;
    localparam int N2 = 4;
    localparam int M  = 8;
    localparam int TILES = (M / N1) * (M / N2);
`ifdef RESULT_WB_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] D [3:0];
    logic [3:0]  valid_D = '0;
    logic        wr_ready = 1'b1;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [15:0] wr_data;
    logic        done;
    logic        overflow;

    always #5 clk = ~clk;

    result_writeback dut (
        .clk      (clk),
        .rst      (rst),
        .D        (D),
        .valid_D  (valid_D),
        .wr_ready (wr_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .done     (done),
        .overflow (overflow)
    );

    typedef struct {
        logic [5:0]  addr;
        logic [15:0] data;
    } exp_t;

    typedef struct {
        int          row;
        logic [15:0] din;
        logic [5:0]  exp_addr;
        logic [15:0] exp_data;
    } vec_t;

    exp_t exp_q [N1][$];
    int   wcnt [N1];
    int   checks = 0;
    int   failures = 0;

    int   acc_cnt;
    bit   done_exp;
    int   done_cnt;
    int   written [64];
    int   mon_row;
    exp_t mon_e;

    function automatic logic [5:0] model_addr(input int i, input int n);
        int t, k, r, c;
        t = (n / N2) % TILES;
        k = n % N2;
        r = t / (M / N2);
        c = t % (M / N2);
        return 6'((r * N1 + i) * M + c * N2 + (N2 - 1 - k));
    endfunction

    function automatic logic [15:0] model_data(input logic [15:0] d);
        if (RELU && d[15]) return 16'h0000;
        return d;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic apply(input logic [3:0] mask, input logic [63:0] dat, input logic [3:0] drop);
        for (int i = 0; i < N1; i++) begin
            D[i]       = dat[16*i +: 16];
            valid_D[i] = mask[i];
            if (mask[i]) begin
                if (!drop[i])
                    exp_q[i].push_back('{model_addr(i, wcnt[i]), model_data(dat[16*i +: 16])});
                wcnt[i]++;
            end
        end
    endtask

    task automatic drive(input logic [3:0] mask, input logic [63:0] dat, input logic [3:0] drop);
        @(posedge clk);
        #1;
        apply(mask, dat, drop);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            valid_D = '0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst     = 1'b1;
        valid_D = '0;
        for (int i = 0; i < N1; i++) begin
            exp_q[i].delete();
            wcnt[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        @(negedge clk);
        check({tag, "_wr_en"},    wr_en,    0);
        check({tag, "_wr_addr"},  wr_addr,  0);
        check({tag, "_wr_data"},  wr_data,  0);
        check({tag, "_done"},     done,     0);
        check({tag, "_overflow"}, overflow, 0);
    endtask

    task automatic drain(input string tag, input int max_cyc);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < max_cyc && !ok; c++) begin
            @(posedge clk);
            #2;
            valid_D = '0;
            ok = !wr_en;
            for (int i = 0; i < N1; i++) if (exp_q[i].size() != 0) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_drain_timeout actual=pending required=empty", tag);
        end
    endtask

    // Scoreboard: each accepted write is matched against the head of its row's queue.
    always @(negedge clk) begin
        if (rst) begin
            acc_cnt  = 0;
            done_exp = 1'b0;
            done_cnt = 0;
            for (int a = 0; a < 64; a++) written[a] = 0;
        end else begin
            check("done_pulse", done, done_exp);
            if (done) done_cnt++;
            done_exp = 1'b0;
            if (wr_en && wr_ready) begin
                mon_row = (int'(wr_addr) / M) % N1;
                if (exp_q[mon_row].size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write actual=addr%0d/0x%0h required=none", wr_addr, wr_data);
                end else begin
                    mon_e = exp_q[mon_row].pop_front();
                    check("sb_wr_addr", wr_addr, mon_e.addr);
                    check("sb_wr_data", wr_data, mon_e.data);
                end
                written[wr_addr]++;
                acc_cnt++;
                if (acc_cnt == M * M) begin
                    acc_cnt  = 0;
                    done_exp = 1'b1;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        tbl [8];
        logic [3:0]  mask;
        logic [63:0] dat;

        tbl[0] = '{0, 16'h0005, 6'd3,  16'h0005};
        tbl[1] = '{0, 16'h1234, 6'd2,  16'h1234};
        tbl[2] = '{1, 16'h0BEE, 6'd11, 16'h0BEE};
        tbl[3] = '{3, 16'h7FFF, 6'd27, 16'h7FFF};
        tbl[4] = '{0, 16'hFFF0, 6'd1,  RELU ? 16'h0000 : 16'hFFF0};
        tbl[5] = '{0, 16'h8000, 6'd0,  RELU ? 16'h0000 : 16'h8000};
        tbl[6] = '{0, 16'h0042, 6'd7,  16'h0042};
        tbl[7] = '{1, 16'h0001, 6'd10, 16'h0001};

        for (int i = 0; i < N1; i++) D[i] = '0;
        do_reset();
        check_reset_state("reset");

        // Single words, one per record, each appearing one cycle after its valid.
        for (int v = 0; v < 8; v++) begin
            mask = 4'b0001 << tbl[v].row;
            dat  = 64'(tbl[v].din) << (16 * tbl[v].row);
            drive(mask, dat, 4'b0000);
            idle(1);
            @(negedge clk);
            check($sformatf("vec%0d_wr_en", v),   wr_en,   1);
            check($sformatf("vec%0d_wr_addr", v), wr_addr, tbl[v].exp_addr);
            check($sformatf("vec%0d_wr_data", v), wr_data, tbl[v].exp_data);
        end
        idle(1);
        @(negedge clk);
        check("idle_wr_en", wr_en, 0);
        drain("table", 20);

        // All rows at once, with a 5-cycle stall on the row-1 write.
        do_reset();
        drive(4'b1111, {16'h0D03, 16'h0D02, 16'h0D01, 16'h0D00}, 4'b0000);
        idle(1);
        @(negedge clk);
        check("simul_row0_addr", wr_addr, 3);
        @(posedge clk);
        #1;
        wr_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            check($sformatf("stall%0d_wr_en", s),   wr_en,   1);
            check($sformatf("stall%0d_wr_addr", s), wr_addr, 11);
            check($sformatf("stall%0d_wr_data", s), wr_data, 16'h0D01);
            @(posedge clk);
            #1;
        end
        wr_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("simul_row2_addr", wr_addr, 19);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("simul_row3_addr", wr_addr, 27);
        drain("simul", 20);

        // Overflow: row 0 word parks in the stalled output register, then row 2 gets 9 words.
        do_reset();
        wr_ready = 1'b0;
        drive(4'b0001, 64'h00AA, 4'b0000);
        for (int j = 0; j < 9; j++) begin
            drive(4'b0100, 64'(16'h0200 + j) << 32, (j == 8) ? 4'b0100 : 4'b0000);
            if (j == 8) begin
                @(negedge clk);
                check("ovf_before_9th", overflow, 0);
            end
        end
        idle(1);
        @(negedge clk);
        check("ovf_after_9th", overflow, 1);
        @(posedge clk);
        #1;
        wr_ready = 1'b1;
        drain("ovf", 40);
        check("ovf_sticky", overflow, 1);
        drive(4'b0100, 64'h0209 << 32, 4'b0000);
        idle(1);
        @(negedge clk);
        check("ovf_next_addr", wr_addr, 50);
        check("ovf_next_data", wr_data, 16'h0209);
        drain("ovf_next", 20);

        // Reset while words are buffered and one is in flight.
        wr_ready = 1'b0;
        drive(4'b1111, {16'h0E03, 16'h0E02, 16'h0E01, 16'h0E00}, 4'b0000);
        idle(2);
        do_reset();
        check_reset_state("midrst");
        wr_ready = 1'b1;
        idle(1);
        @(negedge clk);
        check("midrst_flushed_wr_en", wr_en, 0);
        drive(4'b0001, 64'h0077, 4'b0000);
        idle(1);
        @(negedge clk);
        check("midrst_addr", wr_addr, 3);
        check("midrst_data", wr_data, 16'h0077);
        drain("midrst", 20);

        // Full frame: 64 words with random row skew and random wr_ready.
        do_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            bit all_sent;
            all_sent = 1'b1;
            for (int i = 0; i < N1; i++) if (wcnt[i] < 16) all_sent = 1'b0;
            if (all_sent) break;
            @(posedge clk);
            #1;
            wr_ready = ($urandom_range(0, 3) != 0);
            mask = '0;
            for (int i = 0; i < N1; i++)
                if (wcnt[i] < 16 && exp_q[i].size() < 6 && $urandom_range(0, 3) == 0)
                    mask[i] = 1'b1;
            dat = {$urandom, $urandom};
            apply(mask, dat, 4'b0000);
        end
        @(posedge clk);
        #1;
        valid_D  = '0;
        wr_ready = 1'b1;
        drain("frame", 300);
        idle(2);
        for (int a = 0; a < 64; a++)
            check($sformatf("frame_addr%0d_count", a), written[a], 1);
        check("frame_done_count", done_cnt, 1);
        check("frame_overflow", overflow, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/result_writeback.md
# result_writeback

Downstream stage of the systolic array. Captures the per-row result streams (`D[i]`, `valid_D[i]`) and buffers each row in its own FIFO. Computes the linear output-matrix address of every word and serialises all rows onto a single write port of the M×M result memory, using round-robin arbitration and a valid/ready handshake.

## Interface
- `D_W_ACC`, 16, accumulator/result data width
- `N1`, 4, array rows (number of result streams)
- `N2`, 4, array columns (words per row per tile)
- `M`, 8, matrix dimension; result memory holds M*M words
- `FIFO_DEPTH`, 8, entries per row FIFO (power of two, ≥ N2)

Ports:
- `clk`  in  1  single clock
- `rst`  in  1  reset, synchronous, active-high
- `D`  in  [D_W_ACC-1:0] ×N1 (unpacked `[N1-1:0]`)  result word per array row
- `valid_D`  in  N1  per-row word valid
- `wr_ready`  in  1  result memory accepts a write this cycle
- `wr_en`  out  1  write request valid
- `wr_addr`  out  $clog2(M*M)  linear address, row*M + col
- `wr_data`  out  D_W_ACC  result word
- `done`  out  1  one-cycle pulse: M*M words written
- `overflow`  out  1  sticky: a word was dropped on a full FIFO

## Operation
- Tile order: tile index t = 0..(M/N1)*(M/N2)-1; row slice r = t / (M/N2); column slice c = t % (M/N2).
- Row i word order within a tile: the k-th valid word (k = 0..N2-1) is column N2-1-k of the tile (the farthest PE drains first).
- Address of that word: (r*N1 + i)*M + c*N2 + (N2-1-k).
- Per-row capture logic:
  - Each row keeps its own k counter and t counter, both advanced only on `valid_D[i]`.
  - k wraps at N2, incrementing t.
  - t wraps to 0 after the last tile.
  - Rows are fully independent; arrival skew between rows is irrelevant.
- Capture: on `valid_D[i]`, the entry {addr, data} is pushed into FIFO i.
- Full FIFO:
  - Push to full FIFO i with no same-cycle pop of FIFO i: word dropped, `overflow` set. The k/t counters still advance, so later addresses stay correct.
  - Push to full FIFO i with a same-cycle pop of FIFO i: push accepted, count unchanged.
- Arbiter:
  - Output register idle (`wr_en`=0) or accepted this cycle (`wr_en && wr_ready`): the arbiter selects the first non-empty FIFO starting from `rr_ptr`, pops it, and loads the output register.
  - `rr_ptr` becomes grant+1, modulo N1.
  - No FIFO non-empty: `wr_en` drops to 0.
- Write counter:
  - Counts accepted writes (`wr_en && wr_ready`).
  - At the M*M-th accepted write, `done` pulses the following cycle and the counter wraps to 0.
  - The next frame proceeds with no further action.
- Reset mid-operation: all FIFOs are emptied, counters are zeroed and any in-flight word is discarded; there is no drain.

## Timing
- Reset values: `wr_en`=0, `wr_addr`=0, `wr_data`=0, `done`=0, `overflow`=0, `rr_ptr`=0, all FIFOs empty.
- Latency: `valid_D[i]` high in cycle n, with empty FIFOs and an idle port → `wr_en` high in cycle n+1 with that word.
- Outputs are registered. While `wr_en`=1 and `wr_ready`=0, `wr_addr` and `wr_data` hold stable.
- Throughput: one write per cycle while `wr_ready`=1. N1 simultaneous valids drain over N1 consecutive cycles.
- `wr_ready` is ignored when `wr_en`=0.

## Configuration
- `RESULT_WB_RELU_EN`:
  - Defined: `wr_data` is ReLU of the word; a signed two's-complement negative value is written as 0. Clamping is applied at capture, so there is no added latency.
  - Undefined: the word is passed unchanged.
- Addressing, counts and `overflow` are identical in both builds.

## Structure
- Package `result_wb_pkg`:
  - entry struct typedef {addr, data}
  - address-width and tile-count localparam functions of M/N1/N2
- One sub-module: `row_fifo`:
  - synchronous FIFO, FIFO_DEPTH deep, on the entry struct
  - push/pop/full/empty, same-cycle push+pop when full
  - instantiated N1 times
- Top level holds the per-row k/t counters, arbiter, output register and write counter.

## Test plan
(N1=N2=4, M=8, `wr_ready`=1 unless stated.)
- Single word: `valid_D`=4'b0001, D[0]=0x0005, first tile → next cycle `wr_en`=1, `wr_addr`=3, `wr_data`=0x0005.
- Simultaneous rows: `valid_D`=4'b1111 once, first tile → four consecutive writes, rows 0,1,2,3, addresses 3, 11, 19, 27.
- Backpressure: hold `wr_ready`=0 for 5 cycles during the row-1 write → `wr_addr`/`wr_data` stable all 5 cycles; the write completes on release; no word lost.
- Overflow: `wr_ready`=0; push 9 words into row 2 → `overflow`=1; release → 8 words written. The 9th word's address is skipped and the following word lands on the correct next address.
- Full frame: 64 words across all tiles, random row skew → each address 0..63 written exactly once; `done` pulses once, the cycle after the 64th write.
- `RESULT_WB_RELU_EN` defined: D[0]=0xFFF0 → `wr_data`=0x0000. Undefined → 0xFFF0.
